// File: rtl/fp_div_issue_queue_if.sv
// Request/result handshake bundle for the divider issue queue.
// slave = queue side, master = requester/consumer side.
interface fp_div_issue_queue_if #(
   parameter int TAG_WIDTH = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_a;
   logic [31:0]          in_b;
   logic [TAG_WIDTH-1:0] in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_q;
   logic [TAG_WIDTH-1:0] out_tag;

   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_q, out_tag
   );

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_q, out_tag
   );
endinterface

// File: rtl/fp_div_issue_queue.sv
// Issue/result manager for a fixed-latency FP divider.
// Tags ride a shift register; credits keep the FIFO from overflowing.
module fp_div_issue_queue #(
   parameter int LATENCY   = 32,
   parameter int TAG_WIDTH = 8,
   parameter int OUT_DEPTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   fp_div_issue_queue_if.slave   io,
   output logic [31:0]           div_a,
   output logic [31:0]           div_b,
   input  logic [31:0]           div_q,
   output logic                  busy
);
   localparam int PW = $clog2(OUT_DEPTH);
   localparam int CW = $clog2(OUT_DEPTH + 1);

   logic                 run;
   logic [CW-1:0]        occ;
   logic [CW-1:0]        cnt;
   logic [PW-1:0]        wp;
   logic [PW-1:0]        rp;
   logic [LATENCY:0]     sv;
   logic [TAG_WIDTH-1:0] st [LATENCY+1];
   logic [31:0]          fq [OUT_DEPTH];
   logic [TAG_WIDTH-1:0] ft [OUT_DEPTH];

   logic fire;
   logic pop;
   logic wr;

   assign fire = io.in_valid && io.in_ready;
   assign pop  = io.out_valid && io.out_ready;
   assign wr   = sv[LATENCY];

   // run holds in_ready low while reset is asserted
   assign io.in_ready  = run && (occ < CW'(OUT_DEPTH));
   assign io.out_valid = (cnt != '0);
   assign io.out_q     = fq[rp];
   assign io.out_tag   = ft[rp];
   assign busy         = (occ != '0);

   // credit counter: in-flight ops plus FIFO entries
   always_ff @(posedge clock) begin
      if (!reset) begin
         run <= 1'b0;
         occ <= '0;
      end else begin
         run <= 1'b1;
         case ({fire, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // operand registers feeding the divider
   always_ff @(posedge clock) begin
      if (!reset) begin
         div_a <= '0;
         div_b <= '0;
      end else if (fire) begin
         div_a <= io.in_a;
         div_b <= io.in_b;
      end
   end

   // valid bits of the tag pipe, shifted every cycle
   always_ff @(posedge clock) begin
      if (!reset) begin
         sv <= '0;
      end else begin
         sv <= {sv[LATENCY-1:0], fire};
      end
   end

   // tag payload pipe; only meaningful where sv is set
   always_ff @(posedge clock) begin
      st[0] <= io.in_tag;
      for (int i = 1; i <= LATENCY; i++) begin
         st[i] <= st[i-1];
      end
   end

   // FIFO pointers and fill count
   always_ff @(posedge clock) begin
      if (!reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr) begin
            wp <= wp + PW'(1);
         end
         if (pop) begin
            rp <= rp + PW'(1);
         end
         case ({wr, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // FIFO storage, written as the tagged op leaves the divider
   always_ff @(posedge clock) begin
      if (wr) begin
         fq[wp] <= div_q;
         ft[wp] <= st[LATENCY];
      end
   end
endmodule

// File: tb/tb_fp_div_issue_queue.sv
// Scoreboard bench for fp_div_issue_queue with a stub divider.
// Stub returns hand-computed quotients for the directed vector table.
module tb_fp_div_issue_queue;
   localparam int LAT = 32;
   localparam int NV  = 11;

   logic        clk;
   logic        rst_n;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic        busy;
   int          cyc;
   int          checks;
   int          failures;

   logic [31:0] va [NV];
   logic [31:0] vb [NV];
   logic [31:0] vq [NV];
   logic [31:0] dpipe [LAT];
   logic [39:0] sb [$];

   fp_div_issue_queue_if #(.TAG_WIDTH(8)) bus ();

   fp_div_issue_queue #(
      .LATENCY(LAT), .TAG_WIDTH(8), .OUT_DEPTH(8)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .io    (bus),
      .div_a (div_a),
      .div_b (div_b),
      .div_q (div_q),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] divf(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = 32'hDEADBEEF;
      for (int i = 0; i < NV; i++) begin
         if (va[i] == a && vb[i] == b) r = vq[i];
      end
      return r;
   endfunction

   // stub divider: q reflects operands LAT cycles earlier
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
      dpipe[0] <= divf(div_a, div_b);
   end
   assign div_q = dpipe[LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pop the scoreboard on every accepted result
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", {24'h0, bus.out_tag, bus.out_q}, 64'h0);
         end else begin
            logic [39:0] e;
            e = sb.pop_front();
            chk("result_tag", 64'(bus.out_tag), 64'(e[39:32]));
            chk("result_q", 64'(bus.out_q), 64'(e[31:0]));
         end
      end
   end

   // call at posedge+1; returns at posedge+1 after fire, in_valid still high
   task automatic issue(input int idx, input logic [7:0] tag, input bit push, output int fcyc);
      bit ok;
      ok = 0;
      fcyc = -1;
      bus.in_valid = 1'b1;
      bus.in_a     = va[idx];
      bus.in_b     = vb[idx];
      bus.in_tag   = tag;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) ok = 1;
      end
      if (!ok) begin
         chk("issue_timeout", 64'(tag), 64'hFFFF);
      end else begin
         fcyc = cyc;
         if (push) sb.push_back({tag, vq[idx]});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (busy === 1'b0 && sb.size() == 0) done = 1;
      end
      chk(name, 64'(done), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int f0;
      int f1;
      int fc;
      int n;
      bit seen;
      checks   = 0;
      failures = 0;
      va[0] = 32'h40C00000; vb[0] = 32'h40000000; vq[0] = 32'h40400000;
      va[1] = 32'h3F800000; vb[1] = 32'h40000000; vq[1] = 32'h3F000000;
      va[2] = 32'h41000000; vb[2] = 32'h40800000; vq[2] = 32'h40000000;
      va[3] = 32'h41100000; vb[3] = 32'h40400000; vq[3] = 32'h40400000;
      va[4] = 32'hC0800000; vb[4] = 32'h40000000; vq[4] = 32'hC0000000;
      va[5] = 32'h3F800000; vb[5] = 32'h3F800000; vq[5] = 32'h3F800000;
      va[6] = 32'h41200000; vb[6] = 32'h40800000; vq[6] = 32'h40200000;
      va[7] = 32'h40400000; vb[7] = 32'h3F000000; vq[7] = 32'h40C00000;
      va[8] = 32'h3F800000; vb[8] = 32'h00000000; vq[8] = 32'h7F800000;
      va[9] = 32'h00000000; vb[9] = 32'h00000000; vq[9] = 32'hFFC00000;
      va[10] = 32'h00000001; vb[10] = 32'h3F800000; vq[10] = 32'h00000001;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_div_a", 64'(div_a), 64'd0);
      chk("rst_div_b", 64'(div_b), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rel_busy", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1;

      // single op: 6.0 / 2.0, 34-cycle latency
      issue(0, 8'h11, 1, f0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("single_busy_t1", 64'(busy), 64'd1);
      chk("single_div_a", 64'(div_a), 64'h40C00000);
      chk("single_div_b", 64'(div_b), 64'h40000000);
      seen = 0;
      for (n = 0; n < 100 && !seen; n++) begin
         if (bus.out_valid === 1'b1) seen = 1;
         else @(negedge clk);
      end
      chk("single_latency", 64'(cyc - f0), 64'd34);
      chk("single_busy_last", 64'(busy), 64'd1);
      @(negedge clk);
      chk("single_busy_after", 64'(busy), 64'd0);
      wait_idle("single_idle");

      // back-to-back, tags 0..7, consumer always ready
      @(posedge clk); #1;
      issue(0, 8'h00, 1, f0);
      for (int i = 1; i < 8; i++) issue(i, 8'(i), 1, f1);
      bus.in_valid = 1'b0;
      chk("b2b_accept_span", 64'(f1 - f0), 64'd7);
      @(negedge clk);
      chk("b2b_in_ready_full", 64'(bus.in_ready), 64'd0);
      seen = 0;
      for (n = 0; n < 100 && !seen; n++) begin
         if (bus.out_valid === 1'b1) seen = 1;
         else @(negedge clk);
      end
      chk("b2b_first_out", 64'(cyc - f0), 64'd34);
      n = 0;
      while (bus.out_valid === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("b2b_consecutive", 64'(n), 64'd8);
      wait_idle("b2b_idle");

      // consumer stall: FIFO fills, then drains with fire+pop overlap
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) issue(i, 8'(8'h20 + i), 1, f1);
      bus.in_valid = 1'b0;
      repeat (40) @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_head_tag", 64'(bus.out_tag), 64'h20);
      chk("stall_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a      = va[5];
      bus.in_b      = vb[5];
      bus.in_tag    = 8'h28;
      @(negedge clk);
      chk("occ8_pop_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("occ7_in_ready", 64'(bus.in_ready), 64'd1);
      if (bus.in_ready === 1'b1) sb.push_back({8'h28, vq[5]});
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("occ7_fire_pop_in_ready", 64'(bus.in_ready), 64'd1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) n++;
      end
      @(negedge clk);
      chk("stall_drain_run", 64'(n), 64'd5);
      chk("stall_drain_gap", 64'(bus.out_valid), 64'd0);
      wait_idle("stall_idle");

      // reset with three ops in flight
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) issue(i, 8'(8'h30 + i), 0, f1);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_rel_in_ready", 64'(bus.in_ready), 64'd1);
      chk("midrst_rel_busy", 64'(busy), 64'd0);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) n++;
      end
      chk("midrst_no_results", 64'(n), 64'd0);

      // special values pass through bit-exact
      @(posedge clk); #1;
      issue(8, 8'h40, 1, f1);
      issue(9, 8'h41, 1, f1);
      issue(10, 8'h42, 1, f1);
      bus.in_valid = 1'b0;
      wait_idle("special_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
